// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, state
// encoding, instruction classes and ALU select codes.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT, S_PAUSE
  } state_t;

  typedef enum logic [3:0] {
    ALU_RR, ALU_RI, LDI, LD, ST, BR, JR, NOP, HALT, ILL
  } op_class_t;

  typedef enum logic [1:0] {
    SEL_ADD, SEL_SUB, SEL_AND, SEL_OR
  } alu_sel_t;

endpackage

// File: rtl/cs_decode.sv
// Combinational opcode decoder: maps IR[31:27] to an instruction class and
// the ALU operation used by the register and immediate ALU forms.
module cs_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output op_class_t      op_class,
  output alu_sel_t       alu_sel
);

  always_comb begin
    op_class = ILL;
    alu_sel  = SEL_ADD;
    case (opcode)
      OP_LD:   op_class = LD;
      OP_LDI:  op_class = LDI;
      OP_ST:   op_class = ST;
      OP_ADD:  op_class = ALU_RR;
      OP_SUB:  begin op_class = ALU_RR; alu_sel = SEL_SUB; end
      OP_AND:  begin op_class = ALU_RR; alu_sel = SEL_AND; end
      OP_OR:   begin op_class = ALU_RR; alu_sel = SEL_OR;  end
      OP_ADDI: op_class = ALU_RI;
      OP_ANDI: begin op_class = ALU_RI; alu_sel = SEL_AND; end
      OP_ORI:  begin op_class = ALU_RI; alu_sel = SEL_OR;  end
      OP_BR:   op_class = BR;
      OP_JR:   op_class = JR;
      OP_NOP:  op_class = NOP;
      OP_HALT: op_class = HALT;
      default: op_class = ILL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, per-opcode execute T3-T7, memory
// ready handshake with timeout, halt state. CS_SINGLE_STEP_EN adds a step input.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int TCW         = 5
) (
  input  logic        clock,
  input  logic        clear,
`ifdef CS_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] ir,
  input  logic        CONFF,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MD_read,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Csignout,
  output logic        CONin,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        BRANCH,
  output logic        run,
  output logic        illegal,
  output logic        mem_err
);

`ifdef CS_SINGLE_STEP_EN
  localparam state_t FETCH_START = S_PAUSE;
`else
  localparam state_t FETCH_START = T0;
`endif

  state_t          state, state_nxt;
  op_class_t       op_class;
  alu_sel_t        alu_sel;
  logic [TCW-1:0]  wait_cnt;
  logic            in_wait, timeout;
  logic            alu_en, force_add;

  cs_decode #(.OPW(OPW)) u_decode (
    .opcode   (ir[31 -: OPW]),
    .op_class (op_class),
    .alu_sel  (alu_sel)
  );

  assign in_wait = (state == T1) ||
                   (state == T6 && op_class == LD) ||
                   (state == T7 && op_class == ST);
  assign timeout = in_wait && !mem_ready && (wait_cnt == TCW'(MEM_TIMEOUT - 1));

  // Wait counter restarts on every state change so each wait state gets a fresh budget.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state    <= S_RESET;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_err <= mem_err | timeout;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (in_wait && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = FETCH_START;
`ifdef CS_SINGLE_STEP_EN
      S_PAUSE: if (step) state_nxt = T0;
`else
      S_PAUSE: state_nxt = T0;
`endif
      T0: state_nxt = T1;
      T1: begin
        if (mem_ready)    state_nxt = T2;
        else if (timeout) state_nxt = S_HALT;
      end
      T2: begin
        case (op_class)
          NOP:     state_nxt = FETCH_START;
          HALT:    state_nxt = S_HALT;
          default: state_nxt = T3;
        endcase
      end
      T3: state_nxt = (op_class == JR || op_class == ILL ||
                       op_class == NOP || op_class == HALT) ? FETCH_START : T4;
      T4: state_nxt = T5;
      T5: state_nxt = (op_class == LD || op_class == ST || op_class == BR) ? T6 : FETCH_START;
      T6: begin
        case (op_class)
          LD: begin
            if (mem_ready)    state_nxt = T7;
            else if (timeout) state_nxt = S_HALT;
          end
          ST:      state_nxt = T7;
          default: state_nxt = FETCH_START;
        endcase
      end
      T7: begin
        if (op_class != ST || mem_ready) state_nxt = FETCH_START;
        else if (timeout)                state_nxt = S_HALT;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read, Write} = '0;
    {IRin, Yin, Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {Csignout, CONin, ADD, SUB, AND, OR, BRANCH, illegal} = '0;
    alu_en    = 1'b0;
    force_add = 1'b0;
    run = (state != S_RESET) && (state != S_HALT) && (state != S_PAUSE);
    case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        case (op_class)
          ALU_RR, ALU_RI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          LDI, LD, ST:    begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          BR:             begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          JR:             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          ILL:            illegal = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (op_class)
          ALU_RR:      begin Grc = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zlowin = 1'b1; end
          ALU_RI:      begin Csignout = 1'b1; alu_en = 1'b1; Zlowin = 1'b1; end
          LDI, LD, ST: begin Csignout = 1'b1; force_add = 1'b1; Zlowin = 1'b1; end
          BR:          begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (op_class)
          ALU_RR, ALU_RI, LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          LD, ST:              begin Zlowout = 1'b1; MARin = 1'b1; end
          BR:                  begin Csignout = 1'b1; BRANCH = 1'b1; Zlowin = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        case (op_class)
          LD: begin Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1; end
          ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          BR: begin Zlowout = 1'b1; PCin = CONFF; end
          default: ;
        endcase
      end
      T7: begin
        case (op_class)
          LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    if (alu_en) begin
      case (alu_sel)
        SEL_ADD: ADD = 1'b1;
        SEL_SUB: SUB = 1'b1;
        SEL_AND: AND = 1'b1;
        SEL_OR:  OR  = 1'b1;
        default: ;
      endcase
    end
    if (force_add) ADD = 1'b1;
  end

endmodule
